// File: rtl/mmu_pkg.sv
// Shared definitions for the matrix multiply unit input side.
//   setup_state_t : feeder FSM states (ACCEPT, DRAIN)
//   DEF_WIDTH     : default element width
//   DEF_LENGTH    : default lane count (array rows)
//   cnt_w()       : width of the drain counter for a given lane count
package mmu_pkg;

  typedef enum logic {
    ACCEPT = 1'b0,
    DRAIN  = 1'b1
  } setup_state_t;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_LENGTH = 256;

  // The drain counter holds values up to LENGTH-2; never narrower than one bit.
  function automatic int cnt_w(input int len);
    return (len > 2) ? $clog2(len) : 1;
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Shift register of DELAY stages of WIDTH bits, used as one lane of the
// diagonal skew in front of the systolic array.
//   clk   : clock, rising edge
//   rst_n : asynchronous reset, active-low, clears every stage
//   clr   : synchronous clear, active-high, clears every stage
//   shift : advance the line by one stage
//   din   : value entering stage 0
//   dout  : last stage
module skew_delay_line #(
  parameter int WIDTH = 8,
  parameter int DELAY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [0:DELAY-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DELAY; i++) stage[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < DELAY; i++) stage[i] <= '0;
    end else if (shift) begin
      stage[0] <= din;
      for (int i = 1; i < DELAY; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DELAY-1];

endmodule

// File: rtl/systolic_data_setup.sv
// Input-side feeder for the systolic matrix multiply array. Takes one
// LENGTH-wide vector per valid/ready handshake and presents it to the array
// diagonally skewed (lane r lags lane 0 by r advances). After the last vector
// of a tile it pushes LENGTH-1 zero vectors to flush the diagonal, then pulses
// DONE alongside the final ARRAY_EN.
//   CLK       : clock, rising edge
//   ASYNC_RST : asynchronous reset, active-low
//   SYNC_RST  : synchronous clear, active-high, same effect as reset
//   IN_VALID  : IN_DATA / IN_LAST valid
//   IN_READY  : vector accepted this cycle when IN_VALID also high (registered)
//   IN_DATA   : input vector, element r feeds lane r
//   IN_LAST   : accepted vector closes the tile
//   SKEWED    : skewed row inputs to the array
//   ARRAY_EN  : array enable; SKEWED is valid for capture while high
//   BUSY      : high while flushing the diagonal
//   DONE      : one-cycle pulse with the last ARRAY_EN of a tile
module systolic_data_setup
  import mmu_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int LENGTH = DEF_LENGTH
) (
  input  logic             CLK,
  input  logic             ASYNC_RST,
  input  logic             SYNC_RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_DATA [0:LENGTH-1],
  input  logic             IN_LAST,
  output logic [WIDTH-1:0] SKEWED  [0:LENGTH-1],
  output logic             ARRAY_EN,
  output logic             BUSY,
  output logic             DONE
);

  localparam int CW = cnt_w(LENGTH);

  if (LENGTH < 2) begin : g_length_check
    $error("systolic_data_setup: LENGTH must be at least 2");
  end

  setup_state_t  state, state_next;
  logic [CW-1:0] count, count_next;
  logic          advance;
  logic          ready_next;
  logic          done_next;

  always_comb begin
    state_next = state;
    count_next = count;
    advance    = 1'b0;
    case (state)
      ACCEPT: begin
        if (IN_READY && IN_VALID) begin
          advance = 1'b1;
          if (IN_LAST) begin
            state_next = DRAIN;
            count_next = CW'(LENGTH - 2);
          end
        end
      end
      DRAIN: begin
        advance = 1'b1;
        if (count == '0) state_next = ACCEPT;
        else             count_next = count - CW'(1);
      end
      default: state_next = ACCEPT;
    endcase
    ready_next = (state_next == ACCEPT);
    done_next  = (state == DRAIN) && (count == '0);
  end

  always_ff @(posedge CLK or negedge ASYNC_RST) begin
    if (!ASYNC_RST) begin
      state    <= ACCEPT;
      count    <= '0;
      IN_READY <= 1'b0;
      ARRAY_EN <= 1'b0;
      DONE     <= 1'b0;
    end else if (SYNC_RST) begin
      state    <= ACCEPT;
      count    <= '0;
      IN_READY <= 1'b0;
      ARRAY_EN <= 1'b0;
      DONE     <= 1'b0;
    end else begin
      state    <= state_next;
      count    <= count_next;
      IN_READY <= ready_next;
      ARRAY_EN <= advance;
      DONE     <= done_next;
    end
  end

  assign BUSY = (state == DRAIN);

  // Lane r has r+1 stages, so an element entering all lanes together leaves
  // lane r exactly r advances after lane 0. Zeros are fed while draining.
  for (genvar r = 0; r < LENGTH; r++) begin : g_lane
    logic [WIDTH-1:0] lane_in;
    assign lane_in = (state == DRAIN) ? '0 : IN_DATA[r];

    skew_delay_line #(
      .WIDTH (WIDTH),
      .DELAY (r + 1)
    ) u_line (
      .clk   (CLK),
      .rst_n (ASYNC_RST),
      .clr   (SYNC_RST),
      .shift (advance),
      .din   (lane_in),
      .dout  (SKEWED[r])
    );
  end

endmodule

// File: tb/tb_systolic_data_setup.sv
module tb_systolic_data_setup;

  localparam int W = 8;
  localparam int L = 4;

  typedef logic [L-1:0][W-1:0] vec_t;
  typedef struct packed {
    vec_t sk;
    logic done;
  } exp_t;

  logic         clk = 1'b0;
  logic         async_rst = 1'b0;
  logic         sync_rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data [0:L-1];
  logic         in_last = 1'b0;
  logic [W-1:0] skewed [0:L-1];
  logic         array_en;
  logic         busy;
  logic         done;

  int   nchk = 0;
  int   nfail = 0;
  exp_t sb[$];
  vec_t cur[$];

  systolic_data_setup #(.WIDTH(W), .LENGTH(L)) dut (
    .CLK       (clk),
    .ASYNC_RST (async_rst),
    .SYNC_RST  (sync_rst),
    .IN_VALID  (in_valid),
    .IN_READY  (in_ready),
    .IN_DATA   (in_data),
    .IN_LAST   (in_last),
    .SKEWED    (skewed),
    .ARRAY_EN  (array_en),
    .BUSY      (busy),
    .DONE      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input int a, input int b, input int c, input int d);
    vec_t v;
    v[0] = W'(a); v[1] = W'(b); v[2] = W'(c); v[3] = W'(d);
    return v;
  endfunction

  function automatic vec_t pk();
    vec_t v;
    for (int r = 0; r < L; r++) v[r] = skewed[r];
    return v;
  endfunction

  // Expected array input at advance n of the current tile: lane r shows
  // element r of the vector accepted r advances earlier, zero outside the tile.
  function automatic vec_t exp_at(input int n);
    vec_t v;
    for (int r = 0; r < L; r++) begin
      int idx;
      idx = n - r;
      v[r] = (idx >= 0 && idx < cur.size()) ? cur[idx][r] : '0;
    end
    return v;
  endfunction

  // One clock; outputs sampled 1 time unit after the edge. Every ARRAY_EN
  // cycle is matched against the scoreboard head.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (array_en === 1'b1) begin
      nchk++;
      if (sb.size() == 0) begin
        nfail++;
        $display("FAIL en_unexpected: ARRAY_EN=1 skewed=%h, none expected at %0t", pk(), $time);
      end else begin
        e = sb.pop_front();
        if (pk() !== e.sk) begin
          nfail++;
          $display("FAIL skewed: got %h expected %h at %0t", pk(), e.sk, $time);
        end
        nchk++;
        if (done !== e.done) begin
          nfail++;
          $display("FAIL done_with_en: got %b expected %b at %0t", done, e.done, $time);
        end
      end
    end else begin
      nchk++;
      if (array_en !== 1'b0 || done !== 1'b0) begin
        nfail++;
        $display("FAIL idle: ARRAY_EN=%b DONE=%b expected 0/0 at %0t", array_en, done, $time);
      end
    end
  endtask

  // Present a vector and hold it until accepted; waited = cycles IN_READY was low.
  task automatic send(input vec_t v, input logic last, output int waited);
    int n;
    in_valid = 1'b1;
    in_last  = last;
    for (int r = 0; r < L; r++) in_data[r] = v[r];
    waited = 0;
    while (in_ready !== 1'b1 && waited < 50) begin
      tick();
      waited++;
    end
    nchk++;
    if (in_ready !== 1'b1) begin
      nfail++;
      $display("FAIL accept_timeout: IN_READY=%b after %0d cycles, expected 1", in_ready, waited);
    end else begin
      cur.push_back(v);
      n = cur.size() - 1;
      sb.push_back('{sk: exp_at(n), done: 1'b0});
      if (last) begin
        for (int k = n + 1; k <= n + L - 1; k++)
          sb.push_back('{sk: exp_at(k), done: (k == n + L - 1)});
        cur.delete();
      end
    end
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    nchk++;
    if (sb.size() != 0) begin
      nfail++;
      $display("FAIL %s_drain: %0d outputs still outstanding, expected 0", name, sb.size());
    end
    nchk++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      nfail++;
      $display("FAIL %s_end: IN_READY=%b BUSY=%b expected 1/0", name, in_ready, busy);
    end
  endtask

  task automatic test_reset();
    in_valid = 1'b1;
    for (int r = 0; r < L; r++) in_data[r] = W'(8'hA0 + r);
    async_rst = 1'b0;
    tick();
    tick();
    nchk++;
    if (pk() !== '0 || in_ready !== 1'b0 || array_en !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      nfail++;
      $display("FAIL reset_state: skewed=%h rdy=%b en=%b done=%b busy=%b expected all 0",
               pk(), in_ready, array_en, done, busy);
    end
    async_rst = 1'b1;
    tick();
    nchk++;
    if (in_ready !== 1'b1) begin
      nfail++;
      $display("FAIL reset_release_ready: got %b expected 1", in_ready);
    end
    nchk++;
    if (pk() !== '0) begin
      nfail++;
      $display("FAIL reset_release_skewed: got %h expected 0", pk());
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int w;
    send(mk(1, 2, 3, 4), 1'b1, w);
    for (int i = 0; i < L - 1; i++) begin
      nchk++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
        nfail++;
        $display("FAIL single_drain_%0d: IN_READY=%b BUSY=%b expected 0/1", i, in_ready, busy);
      end
      tick();
    end
    wait_drain("single");
  endtask

  task automatic test_stream();
    int w;
    send(mk(1, 2, 3, 4), 1'b0, w);
    send(mk(5, 6, 7, 8), 1'b1, w);
    wait_drain("stream");
  endtask

  task automatic test_gap();
    int w;
    send(mk(1, 2, 3, 4), 1'b0, w);
    for (int i = 0; i < 2; i++) begin
      tick();
      nchk++;
      if (pk() !== mk(1, 0, 0, 0)) begin
        nfail++;
        $display("FAIL gap_hold_%0d: skewed=%h expected %h", i, pk(), mk(1, 0, 0, 0));
      end
    end
    send(mk(5, 6, 7, 8), 1'b1, w);
    wait_drain("gap");
  endtask

  task automatic test_sync_clear();
    int w;
    send(mk(9, 10, 11, 12), 1'b1, w);
    tick();
    sync_rst = 1'b1;
    sb.delete();
    cur.delete();
    tick();
    nchk++;
    if (pk() !== '0 || in_ready !== 1'b0 || busy !== 1'b0) begin
      nfail++;
      $display("FAIL sync_clear_state: skewed=%h rdy=%b busy=%b expected 0/0/0", pk(), in_ready, busy);
    end
    sync_rst = 1'b0;
    tick();
    nchk++;
    if (in_ready !== 1'b1) begin
      nfail++;
      $display("FAIL sync_release_ready: got %b expected 1", in_ready);
    end
    for (int i = 0; i < L; i++) tick();
    nchk++;
    if (pk() !== '0) begin
      nfail++;
      $display("FAIL sync_after_skewed: got %h expected 0", pk());
    end
  endtask

  task automatic test_back_to_back();
    int w;
    send(mk(21, 22, 23, 24), 1'b1, w);
    send(mk(31, 32, 33, 34), 1'b0, w);
    nchk++;
    if (w != L - 1) begin
      nfail++;
      $display("FAIL b2b_wait: waited %0d cycles expected %0d", w, L - 1);
    end
    send(mk(41, 42, 43, 44), 1'b1, w);
    nchk++;
    if (w != 0) begin
      nfail++;
      $display("FAIL b2b_second_wait: waited %0d cycles expected 0", w);
    end
    wait_drain("b2b");
  endtask

  initial begin
    for (int r = 0; r < L; r++) in_data[r] = '0;
    test_reset();
    test_single();
    test_stream();
    test_gap();
    test_sync_clear();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
